// File: rtl/session_controller.sv
// Coin-operated session controller: arms a countdown timer on a coin, strobes it
// once per TICK_DIV cycles, detects expiry and restarts from queued coin credits.
module session_controller #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned MAX_CREDITS = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Coin,
    input  logic [3:0] ModeSel,
    input  logic       Cancel,
    input  logic [3:0] S1,
    input  logic [3:0] S2,
    input  logic [3:0] S3,
    output logic [3:0] CounterInput,
    output logic       CounterEnable,
    output logic       CounterClear,
    output logic       Busy,
    output logic       Done,
    output logic [1:0] Credits
);

    localparam int unsigned PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [1:0]       CRED_MAX = 2'(MAX_CREDITS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_RUN    = 2'd2,
        ST_EXPIRE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic               started_q, started_d;
    logic [1:0]         credits_q, credits_d;
    logic [3:0]         mode_q, mode_d;
    logic               coin_prev_q, coin_prev_d;

    logic               coin_acc;
    logic               strobe;
    logic               digits_zero;
    logic               cancel_act;
    logic [1:0]         credits_inc;
    logic               clear_c;
    logic               done_c;

    // State register; reset also drops the coin history so a held coin counts once.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            started_q   <= 1'b0;
            credits_q   <= 2'd0;
            mode_q      <= 4'd0;
            coin_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            started_q   <= started_d;
            credits_q   <= credits_d;
            mode_q      <= mode_d;
            coin_prev_q <= coin_prev_d;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        started_d   = started_q;
        credits_d   = credits_q;
        mode_d      = mode_q;
        coin_prev_d = Coin;
        clear_c     = 1'b0;
        done_c      = 1'b0;

        coin_acc    = Coin && !coin_prev_q;
        strobe      = (state_q == ST_RUN) && (presc_q == PRE_MAX);
        digits_zero = (S1 == 4'd0) && (S2 == 4'd0) && (S3 == 4'd0);
        cancel_act  = Cancel && (state_q != ST_IDLE);
        // A coin seen this cycle is credited before any expiry decision consumes it.
        credits_inc = (coin_acc && (credits_q < CRED_MAX)) ? (credits_q + 2'd1) : credits_q;

        case (state_q)
            ST_IDLE: begin
                if (coin_acc) begin
                    mode_d  = ModeSel;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clear_c   = 1'b1;
                presc_d   = '0;
                started_d = 1'b0;
                credits_d = credits_inc;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                credits_d = credits_inc;
                presc_d   = strobe ? '0 : (presc_q + PRE_W'(1));
                if (strobe) begin
                    started_d = 1'b1;
                end
                // Digits read zero right after a clear, so only trust them once counting began.
                if (started_q && !strobe && digits_zero) begin
                    state_d = ST_EXPIRE;
                end
            end
            ST_EXPIRE: begin
                done_c = 1'b1;
                if (credits_inc != 2'd0) begin
                    credits_d = credits_inc - 2'd1;
                    state_d   = ST_CLEAR;
                end else begin
                    credits_d = 2'd0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cancel_act) begin
            state_d   = ST_IDLE;
            credits_d = 2'd0;
            clear_c   = 1'b1;
            done_c    = 1'b0;
        end

        // Reset clears the attached timer alongside the controller.
        if (Reset) begin
            clear_c = 1'b1;
            done_c  = 1'b0;
        end
    end

    assign CounterInput  = mode_q;
    assign CounterEnable = strobe && !cancel_act && !Reset;
    assign CounterClear  = clear_c;
    assign Busy          = (state_q != ST_IDLE);
    assign Done          = done_c;
    assign Credits       = credits_q;

    a_done_clear_excl: assert property (@(posedge Clk) !(Done && CounterClear));
    a_enable_in_run:   assert property (@(posedge Clk) CounterEnable |-> (state_q == ST_RUN));

endmodule

// File: doc/session_controller.md
SESSION_CONTROLLER -- requirements
Module: session_controller

Interface
REQ-001 Parameter TICK_DIV, default 50000000, meaning clock cycles per countdown step (legal range 2 to 2^26).
REQ-002 Parameter MAX_CREDITS, default 3, meaning saturation limit of queued coins (1 to 3).
REQ-003 Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Coin  input  1  synchronous coin level; each 0->1 edge is one coin.
REQ-006 ModeSel  input  4  session mode code, sampled when a session is armed.
REQ-007 Cancel  input  1  synchronous level; aborts the session.
REQ-008 S1, S2, S3  input  4 each  countdown digit status from the timer (seconds units, seconds tens, minutes).
REQ-009 CounterInput  output  4  latched mode code driven to the timer.
REQ-010 CounterEnable  output  1  one-cycle countdown step strobe to the timer.
REQ-011 CounterClear  output  1  one-cycle active-high timer clear request.
REQ-012 Busy  output  1  high in every state except IDLE.
REQ-013 Done  output  1  one-cycle pulse on session expiry.
REQ-014 Credits  output  2  count of queued coins.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, RUN and EXPIRE.
REQ-016 Coin edge detection: a coin SHALL be accepted in the cycle where Coin=1 and its registered value from the previous cycle was 0.
REQ-017 IDLE plus an accepted coin SHALL latch ModeSel into CounterInput and transition to CLEAR.
REQ-018 CLEAR SHALL assert CounterClear for exactly one cycle, zero the prescaler and the started flag, then transition to RUN.
REQ-019 In RUN, the prescaler SHALL count 0..TICK_DIV-1 and wrap to 0.
REQ-020 CounterEnable SHALL be high only in the RUN cycle where the prescaler equals TICK_DIV-1, so the first strobe comes TICK_DIV cycles after entering RUN.
REQ-021 The started flag SHALL set on the first CounterEnable strobe of a session.
REQ-022 Expiry SHALL be detected when the state is RUN, started=1, CounterEnable=0 and S1=S2=S3=0; the FSM SHALL then go to EXPIRE.
REQ-023 EXPIRE SHALL pulse Done for one cycle.
REQ-024 From EXPIRE, the FSM SHALL go to CLEAR with Credits decremented if Credits>0; otherwise it SHALL go to IDLE.
REQ-025 CounterInput SHALL hold its value through any credit-driven restart.
REQ-026 A coin accepted in CLEAR, RUN or EXPIRE SHALL increment Credits, saturating at MAX_CREDITS; excess coins are discarded.
REQ-027 A coin accepted and an EXPIRE decision in the same cycle SHALL be handled as if the increment occurred first; the net Credits change is 0 and the FSM restarts.
REQ-028 Cancel=1 in any non-IDLE state SHALL take priority over all other events in that cycle.
REQ-029 On Cancel, the block SHALL zero Credits, assert CounterClear for one cycle, hold Done low, and go to IDLE.
REQ-030 A coin arriving in the same cycle as Cancel SHALL be discarded.
REQ-031 Cancel in IDLE SHALL have no effect.
REQ-032 CounterEnable SHALL never be high outside RUN.
REQ-033 Done and CounterClear SHALL never be high in the same cycle.

Reset
REQ-034 Reset=1 SHALL force the following on the next edge, from any state including mid-session: state IDLE, prescaler 0, started 0, Credits 0, CounterInput 4'd0, CounterEnable 0, Done 0, Busy 0, and the previous-Coin register 0.
REQ-035 A Coin already held high when Reset is released SHALL count as one coin on the first cycle after reset.
REQ-036 CounterClear SHALL be 1 during every Reset cycle, so the attached timer is cleared together with the controller.

Verification (TICK_DIV=4, timer model attached)
REQ-037 Basic session: coin with ModeSel=1 -> CounterClear at cycle 1, first CounterEnable at cycle 5, digits 1:59 down to 0:00 over 120 strobes, Done once, then IDLE with Busy=0.
REQ-038 Credit restart: 2 extra coins during RUN -> Credits=2, then 2 automatic restarts with Credits 1 then 0, giving 3 Done pulses total.
REQ-039 Saturation: 5 coins during RUN -> Credits=3.
REQ-040 Simultaneous events: coin in the expiry cycle with Credits=0 -> restart, Credits stays 0.
REQ-041 Cancel mid-RUN with Credits=2 -> Credits=0, one CounterClear, no Done, IDLE next cycle.
REQ-042 Reset mid-RUN with Coin held high -> all outputs at reset values; one coin is accepted after release and the block goes to CLEAR.
